muldiv_control: RTL and testbench



---
 rtl/muldiv_control.sv | 230 +++++++++++++++++++++++
 tb/tb_muldiv_control.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_control.sv
`default_nettype none
// ============================================================================
// muldiv_control : iterative MIPS multiply/divide unit owning the HI/LO pair
// Revision 1.0
// ============================================================================
module muldiv_control #(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Issue,
  input  logic              Flush,
  input  logic [5:0]        OpCode,
  input  logic [5:0]        Func,
  input  logic [DATA_W-1:0] Rs_Data,
  input  logic [DATA_W-1:0] Rt_Data,
  output logic              Stall,
  output logic              Busy,
  output logic [DATA_W-1:0] HiLo_Data,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  localparam logic [5:0] OP_TYPE_R = 6'h00;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MTHI    = 6'h11;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MTLO    = 6'h13;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1A;
  localparam logic [5:0] F_DIVU    = 6'h1B;

  localparam int N_MUL = DATA_W / MUL_BITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       hi_q, hi_d;
  logic [DATA_W-1:0]       lo_q, lo_d;
  logic [2*DATA_W-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]       opb_q, opb_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    neg_q, neg_d;
  logic                    rneg_q, rneg_d;
  logic                    div_q, div_d;
  logic                    dz_q, dz_d;

  logic                    grp_w;
  logic                    accept_w;
  logic                    signed_w;
  logic                    a_neg_w, b_neg_w;
  logic [DATA_W-1:0]       a_mag_w, b_mag_w;
  logic [DATA_W+MUL_BITS-1:0] psum_w;
  logic [2*DATA_W-1:0]     mul_next_w;
  logic [DATA_W:0]         rem_shift_w, diff_w;
  logic [2*DATA_W-1:0]     div_next_w;
  logic [2*DATA_W-1:0]     prod_neg_w;
  logic [DATA_W-1:0]       quo_neg_w, rem_neg_w;

  // Decode of the HI/LO instruction group
  always_comb begin
    grp_w = 1'b0;
    if (OpCode == OP_TYPE_R) begin
      case (Func)
        F_MFHI, F_MTHI, F_MFLO, F_MTLO,
        F_MULT, F_MULTU, F_DIV, F_DIVU: grp_w = 1'b1;
        default:                        grp_w = 1'b0;
      endcase
    end
  end

  assign Busy     = (state_q != S_IDLE);
  assign Stall    = Issue & Busy & grp_w;
  assign accept_w = Issue & ~Busy & ~Flush & grp_w;
  assign signed_w = (Func == F_MULT) || (Func == F_DIV);
  assign a_neg_w  = signed_w & Rs_Data[DATA_W-1];
  assign b_neg_w  = signed_w & Rt_Data[DATA_W-1];
  assign a_mag_w  = a_neg_w ? (~Rs_Data + 1'b1) : Rs_Data;
  assign b_mag_w  = b_neg_w ? (~Rt_Data + 1'b1) : Rt_Data;

  always_comb begin
    HiLo_Data = '0;
    if (Issue && grp_w && !Stall) begin
      if (Func == F_MFHI)      HiLo_Data = hi_q;
      else if (Func == F_MFLO) HiLo_Data = lo_q;
    end
  end

  // Shift-add step: low half holds the remaining multiplier digits
  always_comb begin
    psum_w = {{MUL_BITS{1'b0}}, acc_q[2*DATA_W-1:DATA_W]};
    for (int j = 0; j < MUL_BITS; j++) begin
      if (acc_q[j]) psum_w = psum_w + ({{MUL_BITS{1'b0}}, opb_q} << j);
    end
    mul_next_w = {psum_w, acc_q[DATA_W-1:MUL_BITS]};
  end

  // Restoring step: upper half is the partial remainder, lower half the quotient
  always_comb begin
    rem_shift_w = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    diff_w      = rem_shift_w - {1'b0, opb_q};
    if (!diff_w[DATA_W])
      div_next_w = {diff_w[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    else
      div_next_w = {rem_shift_w[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
  end

  assign prod_neg_w = ~acc_q + 1'b1;
  assign quo_neg_w  = ~acc_q[DATA_W-1:0] + 1'b1;
  assign rem_neg_w  = ~acc_q[2*DATA_W-1:DATA_W] + 1'b1;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (accept_w) begin
          case (Func)
            F_MTHI: hi_d = Rs_Data;
            F_MTLO: lo_d = Rs_Data;
            F_MULT, F_MULTU: begin
              acc_d   = {{DATA_W{1'b0}}, b_mag_w};
              opb_d   = a_mag_w;
              neg_d   = a_neg_w ^ b_neg_w;
              rneg_d  = 1'b0;
              div_d   = 1'b0;
              dz_d    = 1'b0;
              cnt_d   = CNT_W'(N_MUL - 1);
              state_d = S_MUL;
            end
            F_DIV, F_DIVU: begin
              div_d  = 1'b1;
              neg_d  = a_neg_w ^ b_neg_w;
              rneg_d = a_neg_w;
              opb_d  = b_mag_w;
              cnt_d  = CNT_W'(DATA_W - 1);
              if (Rt_Data == '0) begin
                acc_d   = {Rs_Data, {DATA_W{1'b1}}};
                dz_d    = 1'b1;
                state_d = S_FIX;
              end else begin
                acc_d   = {{DATA_W{1'b0}}, a_mag_w};
                dz_d    = 1'b0;
                state_d = S_DIV;
              end
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next_w;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DIV: begin
        acc_d = div_next_w;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (dz_q) begin
          {hi_d, lo_d} = acc_q;
        end else if (div_q) begin
          lo_d = neg_q  ? quo_neg_w : acc_q[DATA_W-1:0];
          hi_d = rneg_q ? rem_neg_w : acc_q[2*DATA_W-1:DATA_W];
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg_w : acc_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush abandons the operation and suppresses any pending writeback
    if (Flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
    end
  end

  assign Hi = hi_q;
  assign Lo = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_control.sv
`default_nettype none
// ============================================================================
// tb_muldiv_control : directed bench for muldiv_control (radix-2 and radix-16)
// Revision 1.0
// ============================================================================
module tb_muldiv_control;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clock = 1'b0;
  logic        reset;
  logic        Issue, issue4, Flush;
  logic [5:0]  OpCode, Func;
  logic [31:0] Rs_Data, Rt_Data;
  logic        Stall, Busy, stall4, busy4;
  logic [31:0] HiLo_Data, Hi, Lo, hilo4, hi4, lo4;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  muldiv_control #(.DATA_W(32), .MUL_BITS(1)) dut (
    .clock(clock), .reset(reset), .Issue(Issue), .Flush(Flush),
    .OpCode(OpCode), .Func(Func), .Rs_Data(Rs_Data), .Rt_Data(Rt_Data),
    .Stall(Stall), .Busy(Busy), .HiLo_Data(HiLo_Data), .Hi(Hi), .Lo(Lo)
  );

  muldiv_control #(.DATA_W(32), .MUL_BITS(4)) dut4 (
    .clock(clock), .reset(reset), .Issue(issue4), .Flush(Flush),
    .OpCode(OpCode), .Func(Func), .Rs_Data(Rs_Data), .Rt_Data(Rt_Data),
    .Stall(stall4), .Busy(busy4), .HiLo_Data(hilo4), .Hi(hi4), .Lo(lo4)
  );

  // Issues one op at posedge+1, returns the number of busy cycles observed
  task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit alt, output int cyc);
    Func = f; Rs_Data = a; Rt_Data = b;
    if (alt) issue4 = 1'b1; else Issue = 1'b1;
    @(posedge clock); #1;
    Issue = 1'b0; issue4 = 1'b0;
    cyc = 0;
    while ((alt ? busy4 : Busy) && cyc < 100) begin
      cyc++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; Issue = 1'b0; issue4 = 1'b0; Flush = 1'b0;
    OpCode = 6'h00; Func = 6'h00; Rs_Data = '0; Rt_Data = '0;
    repeat (2) @(posedge clock); #1;
    cmp_cnt++; if (Hi !== 32'h0) begin err_cnt++; $display("FAIL reset_hi: got %h want 00000000", Hi); end
    cmp_cnt++; if (Lo !== 32'h0) begin err_cnt++; $display("FAIL reset_lo: got %h want 00000000", Lo); end
    cmp_cnt++; if (Busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", Busy); end
    cmp_cnt++; if (Stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall: got %b want 0", Stall); end
    cmp_cnt++; if (HiLo_Data !== 32'h0) begin err_cnt++; $display("FAIL reset_hilo: got %h want 00000000", HiLo_Data); end
    cmp_cnt++; if (hilo4 !== 32'h0 || stall4 !== 1'b0) begin err_cnt++; $display("FAIL reset_dut4: hilo %h stall %b want 0/0", hilo4, stall4); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_multu;
    int cyc;
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc);
    cmp_cnt++; if (cyc !== 33) begin err_cnt++; $display("FAIL multu_busy: got %0d want 33", cyc); end
    cmp_cnt++; if (Hi !== 32'hFFFF_FFFE) begin err_cnt++; $display("FAIL multu_hi: got %h want fffffffe", Hi); end
    cmp_cnt++; if (Lo !== 32'h0000_0001) begin err_cnt++; $display("FAIL multu_lo: got %h want 00000001", Lo); end
  endtask

  task automatic test_mult_radix16;
    int cyc;
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, cyc);
    cmp_cnt++; if (cyc !== 9) begin err_cnt++; $display("FAIL mult4_busy: got %0d want 9", cyc); end
    cmp_cnt++; if (hi4 !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL mult4_hi: got %h want ffffffff", hi4); end
    cmp_cnt++; if (lo4 !== 32'hFFFF_FFEB) begin err_cnt++; $display("FAIL mult4_lo: got %h want ffffffeb", lo4); end
    run_op(F_MULTU, 32'h0001_0000, 32'h0003_0000, 1'b1, cyc);
    cmp_cnt++; if (hi4 !== 32'h0000_0003 || lo4 !== 32'h0) begin err_cnt++; $display("FAIL mult4_shift: got %h_%h want 00000003_00000000", hi4, lo4); end
  endtask

  task automatic test_div;
    int cyc;
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc);
    cmp_cnt++; if (cyc !== 33) begin err_cnt++; $display("FAIL div_busy: got %0d want 33", cyc); end
    cmp_cnt++; if (Lo !== 32'hFFFF_FFFD) begin err_cnt++; $display("FAIL div_quo: got %h want fffffffd", Lo); end
    cmp_cnt++; if (Hi !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL div_rem: got %h want ffffffff", Hi); end
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
    cmp_cnt++; if (Lo !== 32'h8000_0000) begin err_cnt++; $display("FAIL div_ovf_quo: got %h want 80000000", Lo); end
    cmp_cnt++; if (Hi !== 32'h0) begin err_cnt++; $display("FAIL div_ovf_rem: got %h want 00000000", Hi); end
    run_op(F_DIVU, 32'hFFFF_FFF9, 32'd10, 1'b0, cyc);
    cmp_cnt++; if (Lo !== 32'h1999_9998 || Hi !== 32'd9) begin err_cnt++; $display("FAIL divu_big: got lo %h hi %h want 19999998/00000009", Lo, Hi); end
  endtask

  task automatic test_div_zero;
    int cyc;
    run_op(F_DIVU, 32'd100, 32'd0, 1'b0, cyc);
    cmp_cnt++; if (cyc !== 1) begin err_cnt++; $display("FAIL divz_busy: got %0d want 1", cyc); end
    cmp_cnt++; if (Hi !== 32'd100) begin err_cnt++; $display("FAIL divz_hi: got %h want 00000064", Hi); end
    cmp_cnt++; if (Lo !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL divz_lo: got %h want ffffffff", Lo); end
    run_op(F_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0, cyc);
    cmp_cnt++; if (Hi !== 32'hFFFF_FFFB || Lo !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL divz_signed: got hi %h lo %h want fffffffb/ffffffff", Hi, Lo); end
  endtask

  task automatic test_dependent_mf;
    int  n;
    bit  stall_ok;
    Func = F_MULT; Rs_Data = 32'd6; Rt_Data = 32'd7; Issue = 1'b1;
    @(posedge clock); #1;
    Func = F_MFLO;
    n = 0; stall_ok = 1'b1;
    while (Busy && n < 100) begin
      if (Stall !== 1'b1) stall_ok = 1'b0;
      n++;
      @(posedge clock); #1;
    end
    cmp_cnt++; if (n !== 33 || !stall_ok) begin err_cnt++; $display("FAIL mflo_stall: cycles %0d steady %b want 33/1", n, stall_ok); end
    cmp_cnt++; if (Stall !== 1'b0) begin err_cnt++; $display("FAIL mflo_release: got %b want 0", Stall); end
    cmp_cnt++; if (HiLo_Data !== 32'd42) begin err_cnt++; $display("FAIL mflo_data: got %h want 0000002a", HiLo_Data); end
    Func = F_MTHI; Rs_Data = 32'd5;
    @(posedge clock); #1;
    cmp_cnt++; if (Hi !== 32'd5 || Busy !== 1'b0) begin err_cnt++; $display("FAIL mthi: hi %h busy %b want 00000005/0", Hi, Busy); end
    Func = F_MFHI;
    #1;
    cmp_cnt++; if (HiLo_Data !== 32'd5) begin err_cnt++; $display("FAIL mfhi_data: got %h want 00000005", HiLo_Data); end
    Func = F_MTLO; Rs_Data = 32'hCAFE_0001;
    @(posedge clock); #1;
    Func = F_MFLO;
    #1;
    cmp_cnt++; if (HiLo_Data !== 32'hCAFE_0001) begin err_cnt++; $display("FAIL mtlo_mflo: got %h want cafe0001", HiLo_Data); end
    Issue = 1'b0;
    #1;
    cmp_cnt++; if (HiLo_Data !== 32'h0) begin err_cnt++; $display("FAIL hilo_idle: got %h want 00000000", HiLo_Data); end
    @(posedge clock); #1;
  endtask

  task automatic test_ignored;
    int cyc;
    OpCode = 6'h08;
    run_op(F_MULT, 32'd3, 32'd3, 1'b0, cyc);
    OpCode = 6'h00;
    cmp_cnt++; if (cyc !== 0) begin err_cnt++; $display("FAIL ignore_opcode: busy %0d want 0", cyc); end
    run_op(6'h20, 32'd3, 32'd3, 1'b0, cyc);
    cmp_cnt++; if (cyc !== 0) begin err_cnt++; $display("FAIL ignore_func: busy %0d want 0", cyc); end
  endtask

  task automatic test_flush_reset;
    int cyc;
    run_op(F_MTHI, 32'h1234, 32'd0, 1'b0, cyc);
    run_op(F_MTLO, 32'h1234, 32'd0, 1'b0, cyc);
    Func = F_DIV; Rs_Data = 32'd100; Rt_Data = 32'd3; Issue = 1'b1;
    @(posedge clock); #1;
    Issue = 1'b0;
    repeat (9) @(posedge clock); #1;
    Flush = 1'b1;
    @(posedge clock); #1;
    Flush = 1'b0;
    cmp_cnt++; if (Busy !== 1'b0) begin err_cnt++; $display("FAIL flush_busy: got %b want 0", Busy); end
    repeat (40) @(posedge clock); #1;
    cmp_cnt++; if (Hi !== 32'h1234 || Lo !== 32'h1234) begin err_cnt++; $display("FAIL flush_hilo: hi %h lo %h want 00001234", Hi, Lo); end
    Func = F_DIV; Issue = 1'b1;
    @(posedge clock); #1;
    Issue = 1'b0;
    repeat (9) @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    cmp_cnt++; if (Busy !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin err_cnt++; $display("FAIL reset_mid: busy %b hi %h lo %h want 0/0/0", Busy, Hi, Lo); end
  endtask

  task automatic test_issue_flush;
    Func = F_MULT; Rs_Data = 32'd2; Rt_Data = 32'd2; Issue = 1'b1; Flush = 1'b1;
    @(posedge clock); #1;
    cmp_cnt++; if (Busy !== 1'b0) begin err_cnt++; $display("FAIL issue_flush_mult: busy %b want 0", Busy); end
    Func = F_MTHI; Rs_Data = 32'hAAAA;
    @(posedge clock); #1;
    Issue = 1'b0; Flush = 1'b0;
    cmp_cnt++; if (Hi !== 32'h0) begin err_cnt++; $display("FAIL issue_flush_mthi: hi %h want 00000000", Hi); end
  endtask

  task automatic test_back_to_back;
    int w;
    int cyc;
    Func = F_MULTU; Rs_Data = 32'd3; Rt_Data = 32'd5; Issue = 1'b1;
    @(posedge clock); #1;
    Func = F_DIVU; Rs_Data = 32'd100; Rt_Data = 32'd7;
    cmp_cnt++; if (Stall !== 1'b1) begin err_cnt++; $display("FAIL b2b_stall: got %b want 1", Stall); end
    w = 0;
    while (Busy && w < 100) begin w++; @(posedge clock); #1; end
    cmp_cnt++; if (w !== 33 || Lo !== 32'd15 || Hi !== 32'd0) begin err_cnt++; $display("FAIL b2b_first: cycles %0d hi %h lo %h want 33/0/f", w, Hi, Lo); end
    @(posedge clock); #1;
    Issue = 1'b0;
    cmp_cnt++; if (Busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_accept: busy %b want 1", Busy); end
    cyc = 0;
    while (Busy && cyc < 100) begin cyc++; @(posedge clock); #1; end
    cmp_cnt++; if (cyc !== 33) begin err_cnt++; $display("FAIL b2b_busy: got %0d want 33", cyc); end
    cmp_cnt++; if (Lo !== 32'd14 || Hi !== 32'd2) begin err_cnt++; $display("FAIL b2b_div: lo %h hi %h want e/2", Lo, Hi); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_radix16();
    test_div();
    test_div_zero();
    test_dependent_mf();
    test_ignored();
    test_flush_reset();
    test_issue_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
